// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the byte-wide RAM/IO bus between the instruction
// cache (word fetches) and the load/store buffer (1/2/4-byte accesses).
// Each request is split into byte beats. Read bytes are reassembled
// little-endian into a 32-bit word. The LSB has priority, but a starvation
// counter lets the icache win after STARVE_LIMIT consecutive LSB grants.
// Optional feature macro: MEM_BUS_ARB_IO_FLUSH_EN. When it is defined, a store
// to 0x30004 (program stop) first waits until io_buffer_full has been low for
// two consecutive cycles, so the UART can drain.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_rdata,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_len,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    IO_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);
`ifdef MEM_BUS_ARB_IO_FLUSH_EN
  localparam logic [31:0] STOP_ADDR = 32'h0003_0004;
`endif

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] starve_cnt_reg, starve_cnt_next;
  logic [31:0]          base_reg, base_next;
  logic [31:0]          wdata_reg, wdata_next;
  logic [31:0]          data_reg, data_next;
  logic [2:0]           k_reg, k_next;
  logic [2:0]           n_reg, n_next;
  logic                 owner_ic_reg, owner_ic_next;
  logic [31:0]          ic_rdata_reg;
  logic [31:0]          ls_rdata_reg;
`ifdef MEM_BUS_ARB_IO_FLUSH_EN
  logic                 flush_wait_reg, flush_wait_next;
  logic                 clean_reg, clean_next;
`endif

  logic [31:0] byte_addr;
  logic        is_io;
  logic        last_write;
  logic [2:0]  cap_idx;
  logic [31:0] assembled;
  logic        grant_ic;
  logic        grant_ls;
  logic [2:0]  ls_n;
  logic        ls_is_io;

  // Address of the current beat; no wrap check, unaligned access is legal.
  assign byte_addr  = base_reg + {29'd0, k_reg};
  assign is_io      = (base_reg[17:16] == 2'b11);
  assign ls_is_io   = (ls_addr[17:16] == 2'b11);
  assign last_write = (k_reg == (n_reg - 3'd1));
  // In READ cycle k the byte addressed in cycle k-1 is on mem_din.
  assign cap_idx    = k_reg - 3'd1;

  // LSB wins unless the icache has waited STARVE_LIMIT grants in a row.
  assign grant_ic = ic_req && (!ls_req || (starve_cnt_reg == STARVE_MAX));
  assign grant_ls = ls_req && !grant_ic;

  // Length code to beat count; the illegal code 2 is treated as a word.
  always_comb begin
    case (ls_len)
      2'd0:    ls_n = 3'd1;
      2'd1:    ls_n = 3'd2;
      default: ls_n = 3'd4;
    endcase
  end

  // Data register with the byte arriving this cycle merged into its lane.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign assembled[8*gi +: 8] = (cap_idx == 3'(gi)) ? mem_din : data_reg[8*gi +: 8];
    end
  endgenerate

  // Bus address/data follow the state alone, so they hold steady during a pause.
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    case (state_reg)
      READ: begin
        if (k_reg < n_reg) mem_a = byte_addr;
      end
      WRITE: begin
        mem_a    = byte_addr;
        mem_dout = wdata_reg[{k_reg[1:0], 3'b000} +: 8];
      end
      default: begin
        mem_a    = '0;
        mem_dout = '0;
      end
    endcase
  end

  // Next-state, arbitration and strobes; with rdy_in low nothing advances.
  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    base_next       = base_reg;
    wdata_next      = wdata_reg;
    data_next       = data_reg;
    k_next          = k_reg;
    n_next          = n_reg;
    owner_ic_next   = owner_ic_reg;
`ifdef MEM_BUS_ARB_IO_FLUSH_EN
    flush_wait_next = flush_wait_reg;
    clean_next      = clean_reg;
`endif
    mem_wr  = 1'b0;
    ic_done = 1'b0;
    ls_done = 1'b0;

    if (rdy_in) begin
      case (state_reg)
        IDLE: begin
          if (!clr_in && (grant_ic || grant_ls)) begin
            k_next    = '0;
            data_next = '0;
            if (grant_ic) begin
              base_next       = ic_addr;
              n_next          = 3'd4;
              owner_ic_next   = 1'b1;
              starve_cnt_next = '0;
              state_next      = READ;
            end else begin
              base_next     = ls_addr;
              n_next        = ls_n;
              owner_ic_next = 1'b0;
              wdata_next    = ls_wdata;
              if (ic_req && (starve_cnt_reg != STARVE_MAX))
                starve_cnt_next = starve_cnt_reg + 1'b1;
              if (!ls_wr) begin
                state_next = READ;
`ifdef MEM_BUS_ARB_IO_FLUSH_EN
              end else if (ls_addr == STOP_ADDR) begin
                state_next      = IO_WAIT;
                flush_wait_next = 1'b1;
                clean_next      = 1'b0;
`endif
              end else if (ls_is_io && io_buffer_full) begin
                state_next = IO_WAIT;
              end else begin
                state_next = WRITE;
              end
            end
          end
        end

        READ: begin
          if (clr_in) begin
            // Abandoned fetch/load: no done pulse.
            state_next      = IDLE;
            starve_cnt_next = '0;
          end else begin
            if (k_reg != 3'd0) data_next = assembled;
            if (k_reg == n_reg) begin
              state_next = IDLE;
              if (owner_ic_reg) ic_done = 1'b1;
              else              ls_done = 1'b1;
            end else begin
              k_next = k_reg + 3'd1;
            end
          end
        end

        WRITE: begin
          // Stores are post-commit, so clr_in is ignored here.
          if (is_io && io_buffer_full) begin
            state_next = IO_WAIT;
          end else begin
            mem_wr = 1'b1;
            if (last_write) begin
              ls_done    = 1'b1;
              state_next = IDLE;
            end else begin
              k_next = k_reg + 3'd1;
            end
          end
        end

        IO_WAIT: begin
`ifdef MEM_BUS_ARB_IO_FLUSH_EN
          if (flush_wait_reg) begin
            if (io_buffer_full) begin
              clean_next = 1'b0;
            end else if (clean_reg) begin
              state_next      = WRITE;
              flush_wait_next = 1'b0;
              clean_next      = 1'b0;
            end else begin
              clean_next = 1'b1;
            end
          end else if (!io_buffer_full) begin
            state_next = WRITE;
          end
`else
          if (!io_buffer_full) state_next = WRITE;
`endif
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      base_reg       <= '0;
      wdata_reg      <= '0;
      data_reg       <= '0;
      k_reg          <= '0;
      n_reg          <= '0;
      owner_ic_reg   <= 1'b0;
`ifdef MEM_BUS_ARB_IO_FLUSH_EN
      flush_wait_reg <= 1'b0;
      clean_reg      <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      base_reg       <= base_next;
      wdata_reg      <= wdata_next;
      data_reg       <= data_next;
      k_reg          <= k_next;
      n_reg          <= n_next;
      owner_ic_reg   <= owner_ic_next;
`ifdef MEM_BUS_ARB_IO_FLUSH_EN
      flush_wait_reg <= flush_wait_next;
      clean_reg      <= clean_next;
`endif
    end
  end

  // Result words hold until that requester's next done.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ic_rdata_reg <= '0;
      ls_rdata_reg <= '0;
    end else begin
      if (ic_done) ic_rdata_reg <= assembled;
      if (ls_done) ls_rdata_reg <= assembled;
    end
  end

  // During the done cycle the last byte comes straight from mem_din.
  assign ic_rdata = ic_done ? assembled : ic_rdata_reg;
  assign ls_rdata = ls_done ? assembled : ls_rdata_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter with a small synchronous RAM model.
module tb_mem_bus_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clr_in;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_done;
  logic [31:0] ic_rdata;
  logic        ls_req;
  logic        ls_wr;
  logic [1:0]  ls_len;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;

  mem_bus_arbiter #(.STARVE_LIMIT(4), .CNT_WIDTH(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
  );

  always #5 clk_in = ~clk_in;

  // RAM model: read data appears the cycle after the address; frozen while paused.
  logic [7:0]  ram [0:4095];
  int          wr_count   = 0;
  int          io_full_wr = 0;
  logic [31:0] last_wr_a  = '0;
  logic [7:0]  last_wr_d  = '0;

  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ram[mem_a[11:0]];
    if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
      wr_count         <= wr_count + 1;
      last_wr_a        <= mem_a;
      last_wr_d        <= mem_dout;
      if (io_buffer_full && (mem_a[17:16] == 2'b11)) io_full_wr <= io_full_wr + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int          t;
    int          nseq;
    int          w0;
    int          grants [6];
    logic [7:0]  exp_b [4];

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h104] = 8'h93; ram[12'h105] = 8'h00; ram[12'h106] = 8'h10; ram[12'h107] = 8'h00;
    ram[12'h010] = 8'hA5;
    ram[12'h400] = 8'h11; ram[12'h401] = 8'h22; ram[12'h402] = 8'h33; ram[12'h403] = 8'h44;
    for (int i = 0; i < 6; i++) grants[i] = 2;

    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; ic_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_len = 2'd0;
    ls_addr = '0; ls_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_mem_a",    mem_a, 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_mem_wr",   32'(mem_wr), 32'h0);
    check("rst_ic_done",  32'(ic_done), 32'h0);
    check("rst_ls_done",  32'(ls_done), 32'h0);
    check("rst_ic_rdata", ic_rdata, 32'h0);
    check("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Icache word fetch from 0x100
    ic_addr = 32'h100; ic_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_in);
      check("ic_fetch_addr", mem_a, 32'h100 + 32'(j));
      check("ic_fetch_early_done", 32'(ic_done), 32'h0);
    end
    @(negedge clk_in);
    check("ic_fetch_done", 32'(ic_done), 32'h1);
    check("ic_fetch_rdata", ic_rdata, 32'h0000_0513);
    $display("txn ic_fetch addr=0x%08h rdata=0x%08h", ic_addr, ic_rdata);
    ic_req = 1'b0;
    @(negedge clk_in);
    check("ic_done_one_cycle", 32'(ic_done), 32'h0);
    check("ic_rdata_hold", ic_rdata, 32'h0000_0513);

    // Word store 0xDEADBEEF to 0x200
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd3; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_in);
      check("st_word_wr",   32'(mem_wr), 32'h1);
      check("st_word_addr", mem_a, 32'h200 + 32'(j));
      check("st_word_byte", 32'(mem_dout), 32'(exp_b[j]));
      check("st_word_done", 32'(ls_done), (j == 3) ? 32'h1 : 32'h0);
    end
    $display("txn ls_store addr=0x%08h data=0x%08h len=3", ls_addr, ls_wdata);
    ls_req = 1'b0;
    @(negedge clk_in);
    check("st_word_idle_wr", 32'(mem_wr), 32'h0);

    // Starvation guard: both requesters held continuously
    ic_req = 1'b1; ic_addr = 32'h100;
    ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'h10;
    nseq = 0; t = 0;
    while (nseq < 6 && t < 200) begin
      @(negedge clk_in);
      t++;
      if (ic_done) begin
        grants[nseq] = 1; nseq++;
        $display("txn grant ic rdata=0x%08h", ic_rdata);
      end else if (ls_done) begin
        grants[nseq] = 0; nseq++;
        check("starve_ls_rdata", ls_rdata, 32'h0000_00A5);
        $display("txn grant ls rdata=0x%08h", ls_rdata);
      end
    end
    ic_req = 1'b0; ls_req = 1'b0;
    check("starve_grant_count", 32'(nseq), 32'd6);
    for (int i = 0; i < 6; i++)
      check("starve_grant_seq", 32'(grants[i]), (i == 4) ? 32'd1 : 32'd0);
    @(negedge clk_in);

    // IO byte store with the UART buffer full for three cycles
    w0 = wr_count;
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd0; ls_addr = 32'h3_0000; ls_wdata = 32'h41;
    repeat (3) begin
      @(negedge clk_in);
      check("io_wait_no_wr", 32'(mem_wr), 32'h0);
    end
    io_buffer_full = 1'b0;
    t = 0;
    while (!ls_done && t < 20) begin
      @(negedge clk_in);
      t++;
    end
    check("io_done", 32'(ls_done), 32'h1);
    check("io_addr", mem_a, 32'h3_0000);
    check("io_byte", 32'(mem_dout), 32'h41);
    $display("txn io_store addr=0x%08h data=0x%02h", ls_addr, mem_dout);
    ls_req = 1'b0;
    @(negedge clk_in);
    check("io_write_count", 32'(wr_count - w0), 32'd1);
    check("io_write_while_full", 32'(io_full_wr), 32'd0);
    check("io_last_data", 32'(last_wr_d), 32'h41);

    // clr_in abandons an icache read at beat 2
    ic_addr = 32'h104; ic_req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_in);
      check("clr_rd_addr", mem_a, 32'h104 + 32'(j));
    end
    clr_in = 1'b1; ic_req = 1'b0;
    @(negedge clk_in);
    check("clr_rd_idle_addr", mem_a, 32'h0);
    clr_in = 1'b0;
    t = 0;
    repeat (5) begin
      @(negedge clk_in);
      if (ic_done) t++;
    end
    check("clr_rd_no_done", 32'(t), 32'd0);
    check("clr_rd_rdata_kept", ic_rdata, 32'h0000_0513);
    $display("txn ic_fetch addr=0x00000104 abandoned by clr");

    // clr_in during a half-word store: store completes
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd1; ls_addr = 32'h300; ls_wdata = 32'h0000_1234;
    @(negedge clk_in);
    check("clr_st_b0_wr",   32'(mem_wr), 32'h1);
    check("clr_st_b0_byte", 32'(mem_dout), 32'h34);
    check("clr_st_b0_done", 32'(ls_done), 32'h0);
    clr_in = 1'b1;
    @(negedge clk_in);
    check("clr_st_b1_wr",   32'(mem_wr), 32'h1);
    check("clr_st_b1_addr", mem_a, 32'h301);
    check("clr_st_b1_byte", 32'(mem_dout), 32'h12);
    check("clr_st_b1_done", 32'(ls_done), 32'h1);
    clr_in = 1'b0; ls_req = 1'b0;
    $display("txn ls_store addr=0x00000300 data=0x1234 len=1 under clr");
    @(negedge clk_in);

    // rdy_in low for five cycles in the middle of a word load
    ls_req = 1'b1; ls_wr = 1'b0; ls_len = 2'd3; ls_addr = 32'h400;
    @(negedge clk_in);
    check("pause_ld_a0", mem_a, 32'h400);
    @(negedge clk_in);
    check("pause_ld_a1", mem_a, 32'h401);
    rdy_in = 1'b0;
    repeat (5) begin
      @(negedge clk_in);
      check("pause_ld_wr",   32'(mem_wr), 32'h0);
      check("pause_ld_done", 32'(ls_done), 32'h0);
      check("pause_ld_addr", mem_a, 32'h401);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    check("pause_ld_a2", mem_a, 32'h402);
    check("pause_ld_done2", 32'(ls_done), 32'h0);
    @(negedge clk_in);
    check("pause_ld_a3", mem_a, 32'h403);
    check("pause_ld_done3", 32'(ls_done), 32'h0);
    @(negedge clk_in);
    check("pause_ld_done", 32'(ls_done), 32'h1);
    check("pause_ld_rdata", ls_rdata, 32'h4433_2211);
    $display("txn ls_load addr=0x00000400 len=3 rdata=0x%08h with pause", ls_rdata);
    ls_req = 1'b0;
    @(negedge clk_in);
    check("pause_ld_rdata_hold", ls_rdata, 32'h4433_2211);

    // rdy_in low during a byte store forces mem_wr low and delays the write
    w0 = wr_count;
    ls_req = 1'b1; ls_wr = 1'b1; ls_len = 2'd0; ls_addr = 32'h500; ls_wdata = 32'h77;
    @(negedge clk_in);
    check("pause_st_wr_active", 32'(mem_wr), 32'h1);
    rdy_in = 1'b0;
    #1;
    check("pause_st_wr_forced", 32'(mem_wr), 32'h0);
    check("pause_st_done_sup", 32'(ls_done), 32'h0);
    repeat (2) begin
      @(negedge clk_in);
      check("pause_st_wr_held", 32'(mem_wr), 32'h0);
    end
    rdy_in = 1'b1;
    #1;
    check("pause_st_wr_resume", 32'(mem_wr), 32'h1);
    check("pause_st_done", 32'(ls_done), 32'h1);
    ls_req = 1'b0;
    @(negedge clk_in);
    check("pause_st_count", 32'(wr_count - w0), 32'd1);
    check("pause_st_ram", 32'(ram[12'h500]), 32'h77);
    $display("txn ls_store addr=0x00000500 data=0x77 len=0 with pause");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Time-shares the single byte-wide RAM/IO bus between two requesters: the instruction cache (word fetches) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into byte beats and reassembles read data into a 32-bit word.
- Enforces LSB-first priority, with a starvation guard for the icache.
- Honours pipeline clear (clr_in), pause (rdy_in) and UART back-pressure (io_buffer_full).

Parameters:
- STARVE_LIMIT, 4, max consecutive LSB grants while ic_req is pending before the icache wins the next grant.
- CNT_WIDTH, 3, width of the starvation counter (must hold STARVE_LIMIT).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  low: freeze all state; mem_wr forced 0
- clr_in  input  1  misprediction flush, synchronous, sampled when rdy_in=1
- mem_din  input  8  RAM/IO read byte; valid the cycle after its address is driven
- mem_dout  output  8  write byte
- mem_a  output  32  byte address
- mem_wr  output  1  1 = write
- io_buffer_full  input  1  UART TX buffer full
- ic_req  input  1  icache word-fetch request, level, held until ic_done
- ic_addr  input  32  fetch address, word-aligned
- ic_done  output  1  one-cycle pulse, ic_rdata valid
- ic_rdata  output  32  fetched word, little-endian
- ls_req  input  1  LSB request, level, held until ls_done
- ls_wr  input  1  1 = store
- ls_len  input  2  0 = byte, 1 = half, 3 = word (2 is illegal, treated as word)
- ls_addr  input  32  access address
- ls_wdata  input  32  store data, low bytes used
- ls_done  output  1  one-cycle pulse
- ls_rdata  output  32  load data, zero-filled above len (LSB does sign extension)

Behaviour:
- Reset: state IDLE, starve_cnt=0. All outputs 0 (mem_a=0, mem_dout=0, mem_wr=0, ic_done=0, ls_done=0, ic_rdata=0, ls_rdata=0).
- Requests and addresses are sampled only in IDLE. Requester inputs must stay stable until done.
- States:
  - IDLE: select a grant, latch addr/len/wdata, set byte index k=0. Go to READ, WRITE or IO_WAIT.
  - READ: cycle j drives mem_a=base+j for j<n; byte j-1 is captured from mem_din into the data register. Done pulse in the cycle the last byte is captured, then IDLE. Total n+1 cycles from leaving IDLE; an icache word takes 5 cycles.
  - WRITE: one byte per cycle, mem_wr=1, mem_a=base+k, mem_dout=wdata[8k+7:8k]. Done pulses with the last byte, then IDLE. Total n cycles.
  - IO_WAIT: entered for a store with addr[17:16]=2'b11 while io_buffer_full=1. Drives mem_wr=0, mem_a=0. Moves to WRITE on the first cycle io_buffer_full=0.
- io_buffer_full is re-checked before every IO write byte. IO reads are never replayed: each byte address is driven exactly once.
- Arbitration:
  - ls_req wins over ic_req, except when starve_cnt==STARVE_LIMIT and ic_req=1; then the icache wins.
  - starve_cnt increments on an LSB grant while ic_req=1, and clears on any icache grant.
  - Saturates at STARVE_LIMIT.
- Back-to-back: a done cycle returns to IDLE. The next grant happens the following cycle; one idle bus cycle between transactions.
- clr_in:
  - Abandons an in-flight READ (either requester) with no done pulse, returns to IDLE next cycle, clears starve_cnt.
  - An in-flight WRITE or IO_WAIT continues to completion, since stores are only issued post-commit, and its ls_done still pulses.
  - In IDLE, requests are not granted that cycle.
- rdy_in=0: state, counters and data register are frozen; mem_wr=0; done pulses suppressed. The system guarantees mem_din holds across the pause. Operation resumes identically.
- Address wrap: base+k uses 32-bit add with no wrap check; unaligned access is legal.
- Done pulses are exactly one cycle. ic_rdata and ls_rdata hold their value until the next done for that requester.

Optional Feature:
- Macro MEM_BUS_ARB_IO_FLUSH_EN.
- Defined: entry into WRITE toward address 0x30004 (program stop) first waits in IO_WAIT until io_buffer_full=0 for 2 consecutive cycles, so the UART drains.
- Undefined: 0x30004 is treated like any IO store (single io_buffer_full check per byte).

Test Plan:
- ic_req, ic_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a 0x100..0x103 over 4 cycles; ic_done in cycle 5 with ic_rdata=0x00000513.
- ls_req store len=3 to 0x200, wdata=0xDEADBEEF -> mem_wr=1 for 4 cycles, bytes EF,BE,AD,DE at 0x200..0x203; ls_done on 4th cycle.
- ic_req and ls_req continuously asserted, STARVE_LIMIT=4 -> grant sequence LSB,LSB,LSB,LSB,IC,LSB...
- Byte store 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write of 0x41; no duplicate.
- icache READ at beat 2, clr_in=1 -> no ic_done, IDLE next cycle. A store in flight under clr_in completes all bytes and gives ls_done.
- rdy_in=0 for 5 cycles mid 4-byte load -> mem_wr=0 throughout, ls_rdata correct, total active cycles unchanged (5).
